// File: rtl/axis_arb_pkg.sv
// Shared constants for the packet-granular AXI-Stream arbiter.
// FSM encodings are kept as plain constants so legacy code can compare against them.
package axis_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/axis_pkt_arbiter_rr_pick.sv
// Round-robin pick: first set req_valid bit at or above rr_ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int unsigned cand;

  // Walking outward from rr_ptr gives the rotate/encode/unrotate result without a barrel shifter.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - 32'(NUM_REQ);
      if (!found && req_valid[IDX_W'(cand)]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one AXI-Stream register slice.
// Optional per-requester packet counters: define AXIS_ARB_PKT_CNT_EN.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy,
  output logic [IDX_W-1:0]           grant_idx
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  output logic [NUM_REQ*PKT_CNT_W-1:0] pkt_cnt
`endif
);

  logic             state;
  logic [IDX_W-1:0] rr_ptr;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             xfer_last;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  assign busy      = (state == ST_BUSY);
  assign xfer_last = busy && req_valid[grant_idx] && out_ready && req_last[grant_idx];

  // out_valid depends only on state and the granted valid, never on out_ready.
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    req_ready = '0;
    if (busy) begin
      out_data             = req_data[grant_idx*DATA_W +: DATA_W];
      out_valid            = req_valid[grant_idx];
      out_last             = req_last[grant_idx];
      req_ready[grant_idx] = out_ready;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
    end else if (state == ST_IDLE) begin
      if (pick_found) begin
        grant_idx <= pick_idx;
        state     <= ST_BUSY;
      end
    end else if (xfer_last) begin
      state  <= ST_IDLE;
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef AXIS_ARB_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (xfer_last) begin
      cnt_q[grant_idx] <= cnt_q[grant_idx] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign pkt_cnt[g*PKT_CNT_W +: PKT_CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed self-checking bench for axis_pkt_arbiter (NUM_REQ=4, DATA_W=8).
module tb_axis_pkt_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_last;
  logic                      out_ready;
  logic                      busy;
  logic [1:0]                grant_idx;
`ifdef AXIS_ARB_PKT_CNT_EN
  logic [NUM_REQ*16-1:0]     pkt_cnt;
`endif

  axis_pkt_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .grant_idx (grant_idx)
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Per-requester source models: packet contents, length, progress, repeat and hold flags.
  logic [7:0]  src_mem  [NUM_REQ][8];
  int unsigned src_len  [NUM_REQ];
  int unsigned src_beat [NUM_REQ];
  bit          src_act  [NUM_REQ];
  bit          src_rep  [NUM_REQ];
  bit          src_hold [NUM_REQ];
  logic [7:0]  obs_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*DATA_W +: DATA_W] = src_mem[i][src_beat[i]];
      req_valid[i] = src_act[i] && !src_hold[i];
      req_last[i]  = (src_beat[i] == src_len[i] - 1);
    end
    #1;
  endtask

  // One clock: note accepted beats before the edge, advance sources after it.
  task automatic cycle();
    logic [NUM_REQ-1:0] acc;
    acc = req_valid & req_ready;
    if (out_valid && out_ready) obs_q.push_back(out_data);
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        if (src_beat[i] == src_len[i] - 1) begin
          src_beat[i] = 0;
          src_act[i]  = src_rep[i];
        end else begin
          src_beat[i]++;
        end
      end
    end
    drive_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    out_ready = 1'b1;
    req_data  = '0;
    req_valid = '0;
    req_last  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_len[i] = 1; src_beat[i] = 0; src_act[i] = 0; src_rep[i] = 0; src_hold[i] = 0;
      for (int b = 0; b < 8; b++) src_mem[i][b] = 8'h00;
    end
    drive_inputs();
    repeat (2) @(posedge clk);
    #2;

    // Reset state
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_last", 32'(out_last), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_grant", 32'(grant_idx), 32'h0);
    rst = 1'b1;
    cycle();

    // Single requester 2, three beats
    src_mem[2][0] = 8'h11; src_mem[2][1] = 8'h22; src_mem[2][2] = 8'h33;
    src_len[2] = 3; src_act[2] = 1;
    drive_inputs();
    chk("s_idle_busy", 32'(busy), 32'h0);
    chk("s_idle_ready", 32'(req_ready), 32'h0);
    chk("s_idle_valid", 32'(out_valid), 32'h0);
    cycle();
    chk("s_busy", 32'(busy), 32'h1);
    chk("s_grant", 32'(grant_idx), 32'h2);
    chk("s_d0", 32'(out_data), 32'h11);
    chk("s_v0", 32'(out_valid), 32'h1);
    chk("s_l0", 32'(out_last), 32'h0);
    chk("s_ready", 32'(req_ready), 32'h4);
    cycle();
    chk("s_d1", 32'(out_data), 32'h22);
    chk("s_l1", 32'(out_last), 32'h0);
    cycle();
    chk("s_d2", 32'(out_data), 32'h33);
    chk("s_l2", 32'(out_last), 32'h1);
    cycle();
    chk("s_end_busy", 32'(busy), 32'h0);
    chk("s_end_valid", 32'(out_valid), 32'h0);

    // Reset in the middle of requester 1's packet
    for (int b = 0; b < 5; b++) src_mem[1][b] = 8'h21 + 8'(b);
    src_len[1] = 5; src_act[1] = 1;
    drive_inputs();
    cycle();
    cycle();
    cycle();
    chk("r_third_beat", 32'(out_data), 32'h23);
    chk("r_pre_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("r_busy", 32'(busy), 32'h0);
    chk("r_valid", 32'(out_valid), 32'h0);
    chk("r_ready", 32'(req_ready), 32'h0);
    chk("r_grant", 32'(grant_idx), 32'h0);
    src_act[1] = 0; src_beat[1] = 0;
    drive_inputs();
    cycle();
    rst = 1'b1;
    cycle();
    chk("r_after_busy", 32'(busy), 32'h0);

    // Round-robin: all four valid with repeating two-beat packets
    for (int i = 0; i < NUM_REQ; i++) begin
      src_mem[i][0] = 8'(i * 16);
      src_mem[i][1] = 8'(i * 16 + 1);
      src_len[i] = 2; src_beat[i] = 0; src_act[i] = 1; src_rep[i] = 1;
    end
    drive_inputs();
    for (int t = 0; t < 15; t++) begin
      int k;
      int ph;
      k  = t / 3;
      ph = t % 3;
      if (ph == 0) begin
        chk("rr_gap_busy", 32'(busy), 32'h0);
        chk("rr_gap_valid", 32'(out_valid), 32'h0);
      end else begin
        chk("rr_busy", 32'(busy), 32'h1);
        chk("rr_grant", 32'(grant_idx), 32'(k % 4));
        chk("rr_data", 32'(out_data), 32'((k % 4) * 16 + ph - 1));
        chk("rr_last", 32'(out_last), 32'(ph == 2));
      end
      cycle();
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      src_act[i] = 0; src_rep[i] = 0; src_beat[i] = 0;
    end
    drive_inputs();

    // Backpressure on requester 1
    src_mem[1][0] = 8'h40; src_mem[1][1] = 8'h41; src_mem[1][2] = 8'h42;
    src_len[1] = 3; src_act[1] = 1;
    obs_q.delete();
    drive_inputs();
    cycle();
    chk("bp_grant", 32'(grant_idx), 32'h1);
    cycle();
    out_ready = 1'b0;
    drive_inputs();
    for (int s = 0; s < 3; s++) begin
      chk("bp_data", 32'(out_data), 32'h41);
      chk("bp_last", 32'(out_last), 32'h0);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_ready", 32'(req_ready), 32'h0);
      cycle();
    end
    out_ready = 1'b1;
    drive_inputs();
    cycle();
    cycle();
    chk("bp_end_busy", 32'(busy), 32'h0);
    chk("bp_count", 32'(obs_q.size()), 32'h3);
    if (obs_q.size() == 3) begin
      chk("bp_beat0", 32'(obs_q[0]), 32'h40);
      chk("bp_beat1", 32'(obs_q[1]), 32'h41);
      chk("bp_beat2", 32'(obs_q[2]), 32'h42);
    end

    // Gap in valid from granted requester 3 while requester 0 waits
    src_mem[3][0] = 8'h31; src_mem[3][1] = 8'h32; src_mem[3][2] = 8'h33;
    src_len[3] = 3; src_act[3] = 1;
    drive_inputs();
    cycle();
    chk("g_grant", 32'(grant_idx), 32'h3);
    src_mem[0][0] = 8'h50; src_len[0] = 1; src_act[0] = 1;
    drive_inputs();
    cycle();
    src_hold[3] = 1;
    drive_inputs();
    for (int s = 0; s < 2; s++) begin
      chk("g_hold_busy", 32'(busy), 32'h1);
      chk("g_hold_grant", 32'(grant_idx), 32'h3);
      chk("g_hold_valid", 32'(out_valid), 32'h0);
      chk("g_hold_ready0", 32'(req_ready[0]), 32'h0);
      cycle();
    end
    src_hold[3] = 0;
    drive_inputs();
    chk("g_d1", 32'(out_data), 32'h32);
    cycle();
    chk("g_d2", 32'(out_data), 32'h33);
    chk("g_l2", 32'(out_last), 32'h1);
    cycle();
    chk("g_idle", 32'(busy), 32'h0);
    cycle();
    chk("g_next_grant", 32'(grant_idx), 32'h0);
    chk("g_next_data", 32'(out_data), 32'h50);
    chk("g_next_last", 32'(out_last), 32'h1);
    cycle();
    chk("g_end_busy", 32'(busy), 32'h0);

`ifdef AXIS_ARB_PKT_CNT_EN
    // Packet counters: five single-beat packets from requester 1 after a fresh reset
    rst = 1'b0;
    #1;
    chk("c_rst", 32'(pkt_cnt[31:0]), 32'h0);
    cycle();
    rst = 1'b1;
    src_mem[1][0] = 8'h60; src_len[1] = 1; src_beat[1] = 0;
    for (int p = 0; p < 5; p++) begin
      src_act[1] = 1;
      drive_inputs();
      cycle();
      cycle();
    end
    chk("c_req0", 32'(pkt_cnt[15:0]), 32'h0);
    chk("c_req1", 32'(pkt_cnt[31:16]), 32'h5);
    chk("c_req2", 32'(pkt_cnt[47:32]), 32'h0);
    chk("c_req3", 32'(pkt_cnt[63:48]), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
Name: axis_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one 8-bit AXI-Stream register stage between NUM_REQ upstream requesters.
- Sits directly in front of the 8-bit AXI register slice. A grant is held from the first accepted beat until the beat carrying last is accepted, so packets never interleave.
- The output side connects straight to the register slice's data_in/m_valid/m_ready/m_last.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_W, 8, beat width in bits.
- IDX_W, $clog2(NUM_REQ), grant index width; derived, never overridden.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- req_data  in  NUM_REQ*DATA_W  flattened requester data; requester i at bits [i*DATA_W +: DATA_W].
- req_valid  in  NUM_REQ  per-requester valid.
- req_last  in  NUM_REQ  per-requester end-of-packet flag.
- req_ready  out  NUM_REQ  per-requester ready.
- out_data  out  DATA_W  to register slice data_in.
- out_valid  out  1  to register slice m_valid.
- out_last  out  1  to register slice m_last.
- out_ready  in  1  from register slice m_ready.
- busy  out  1  high while a packet grant is held.
- grant_idx  out  IDX_W  index of current/last granted requester.

Behaviour:
- Reset values: state=IDLE; rr_ptr=0; grant_idx=0; busy=0; out_valid=0; out_last=0; out_data=0; req_ready=0.
  - Reset takes effect immediately on rst falling, including mid-packet. The partial packet is abandoned and not resumed.
- Two-state FSM, IDLE and BUSY.
- IDLE:
  - All req_ready=0 and out_valid=0.
  - If any req_valid is high, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register that index into grant_idx and go to BUSY next cycle. Arbitration latency is 1 cycle.
- BUSY:
  - out_data, out_valid and out_last are combinational muxes of requester grant_idx.
  - req_ready[grant_idx] = out_ready; all other req_ready = 0.
  - A beat transfers when req_valid[grant_idx] && out_ready.
  - On a transfer with req_last[grant_idx]=1: go to IDLE, set rr_ptr = (grant_idx+1) mod NUM_REQ, drop busy.
  - The granted requester deasserting valid mid-packet does not release the grant. The FSM waits in BUSY indefinitely.
- Fairness:
  - One idle cycle between consecutive packets.
  - With all requesters continuously valid, grant order is 0,1,2,...,NUM_REQ-1,0.
  - The last-served requester has lowest priority in the next arbitration.
- Single-beat packet (valid+last on first beat): BUSY for exactly that one transfer cycle, then IDLE.
- Simultaneous new requests during BUSY: ignored until return to IDLE. Non-granted requesters see req_ready=0.
- Stall: out_ready=0 holds all outputs stable. AXI rule: valid/data/last of the granted requester are passed through unchanged.
- No combinational path from out_ready to out_valid.

Optional Feature:
- Macro: AXIS_ARB_PKT_CNT_EN.
- Defined:
  - Adds output pkt_cnt (NUM_REQ*16 bits, flattened).
  - One 16-bit counter per requester, incremented on each accepted last beat of that requester.
  - Counters wrap 0xFFFF -> 0 and reset to 0.
- Not defined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package axis_arb_pkg:
  - FSM state encoding: ST_IDLE=1'b0, ST_BUSY=1'b1.
  - Counter width constant PKT_CNT_W=16.
- One natural sub-module: rr_pick, a combinational rotate/priority-encode/unrotate that takes req_valid and rr_ptr and produces found and idx.

Test Plan:
- Reset mid-packet: requester 1 BUSY, third beat, rst=0 -> busy=0, out_valid=0, req_ready=0 same cycle. After release, IDLE with rr_ptr=0.
- Single requester: req 2 sends 3-beat packet 0x11,0x22,0x33 with out_ready=1 -> out_data shows 0x11,0x22,0x33 on consecutive cycles after a 1-cycle grant delay. out_last high only on 0x33; busy falls the next cycle.
- Round-robin: all 4 requesters valid with 2-beat packets, out_ready=1 -> grant_idx sequence 0,1,2,3,0. Each packet is separated by one idle cycle.
- Backpressure: mid-packet, out_ready=0 for 3 cycles -> out_data/out_last stable, req_ready[g]=0. Resume delivers remaining beats with none lost or duplicated.
- Gap in valid: granted requester 3 drops valid for 2 cycles mid-packet while requester 0 is valid -> grant stays 3, req_ready[0]=0 throughout. Packet completes, then requester 0 is granted.
- AXIS_ARB_PKT_CNT_EN: 5 packets from requester 1 -> pkt_cnt[31:16]=5, others 0. Preload-equivalent: send 65536 packets -> counter wraps to 0.
